// File: rtl/time_setter.sv
// Key-driven time editor: synchronizes and debounces three keys, steps hour/minute/second fields, and pulses load on commit.
// Optional auto-repeat on held up/down keys is enabled with `define TIME_SETTER_REPEAT_EN.
module time_setter #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic [5:0] hour_now,
    input  logic [5:0] minute_now,
    input  logic [5:0] second_now,
    output logic       set_en,
    output logic [5:0] hour_set,
    output logic [5:0] minute_set,
    output logic [5:0] second_set,
    output logic [1:0] field_sel,
    output logic       load
);

    typedef enum logic [2:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  w_key_raw;
    logic [2:0]  r_sync0, r_sync1, r_db, r_db_d, r_armed;
    logic [1:0]  r_sync_vld;
    logic [19:0] r_db_cnt [3];
    logic [2:0]  w_press;
    logic        w_in_set, w_rpt_up, w_rpt_down, w_up, w_down, w_step_en;
    logic [5:0]  r_hour_set, r_minute_set, r_second_set;

    function automatic logic [5:0] f_inc(input logic [5:0] v, input logic [5:0] vmax);
        if (v > vmax)       return 6'd0;
        else if (v == vmax) return 6'd0;
        else                return v + 6'd1;
    endfunction

    function automatic logic [5:0] f_dec(input logic [5:0] v, input logic [5:0] vmax);
        if (v > vmax)       return 6'd0;
        else if (v == 6'd0) return vmax;
        else                return v - 6'd1;
    endfunction

    // bit 0 = mode, bit 1 = up, bit 2 = down
    assign w_key_raw = {key_down, key_up, key_mode};

    // A key is armed only once it has been seen released after reset,
    // so a key held through reset cannot produce a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync0    <= '0;
            r_sync1    <= '0;
            r_sync_vld <= '0;
            r_db       <= '0;
            r_db_d     <= '0;
            r_armed    <= '0;
            for (int k = 0; k < 3; k++) r_db_cnt[k] <= '0;
        end else begin
            r_sync0    <= w_key_raw;
            r_sync1    <= r_sync0;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_db_d     <= r_db;
            for (int k = 0; k < 3; k++) begin
                if (r_sync_vld[1] && !r_sync1[k]) r_armed[k] <= 1'b1;
                if (r_sync1[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DEBOUNCE_CYCLES - 20'd1) begin
                    r_db[k]     <= r_sync1[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 20'd1;
                end
            end
        end
    end

    assign w_press  = r_db & ~r_db_d & r_armed;
    assign w_in_set = (r_state == SET_HOUR) || (r_state == SET_MIN) || (r_state == SET_SEC);

`ifdef TIME_SETTER_REPEAT_EN
    logic [23:0] r_rpt_cnt;
    logic        w_rpt_hold, w_rpt;

    assign w_rpt_hold = w_in_set && ((r_db[1] & r_armed[1]) != (r_db[2] & r_armed[2]));
    assign w_rpt      = w_rpt_hold && (r_rpt_cnt == REPEAT_CYCLES - 24'd1);

    always_ff @(posedge clk) begin
        if (!rst_n || !w_rpt_hold) r_rpt_cnt <= '0;
        else if (w_rpt)            r_rpt_cnt <= '0;
        else                       r_rpt_cnt <= r_rpt_cnt + 24'd1;
    end

    assign w_rpt_up   = w_rpt & r_db[1];
    assign w_rpt_down = w_rpt & r_db[2];
`else
    assign w_rpt_up   = 1'b0 & (REPEAT_CYCLES != 24'd0);
    assign w_rpt_down = 1'b0;
`endif

    assign w_up      = w_press[1] | w_rpt_up;
    assign w_down    = w_press[2] | w_rpt_down;
    assign w_step_en = w_in_set && (w_up != w_down) && !w_press[0];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        set_en      = 1'b0;
        field_sel   = 2'd0;
        load        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press[0]) w_state_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                set_en    = 1'b1;
                field_sel = 2'd1;
                if (w_press[0]) w_state_nxt = SET_MIN;
            end
            SET_MIN: begin
                set_en    = 1'b1;
                field_sel = 2'd2;
                if (w_press[0]) w_state_nxt = SET_SEC;
            end
            SET_SEC: begin
                set_en    = 1'b1;
                field_sel = 2'd3;
                if (w_press[0]) w_state_nxt = COMMIT;
            end
            COMMIT: begin
                set_en      = 1'b1;
                load        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hour_set   <= '0;
            r_minute_set <= '0;
            r_second_set <= '0;
        end else if (r_state == IDLE && w_press[0]) begin
            r_hour_set   <= hour_now;
            r_minute_set <= minute_now;
            r_second_set <= second_now;
        end else if (w_step_en) begin
            case (r_state)
                SET_HOUR: r_hour_set   <= w_up ? f_inc(r_hour_set, 6'd23)   : f_dec(r_hour_set, 6'd23);
                SET_MIN:  r_minute_set <= w_up ? f_inc(r_minute_set, 6'd59) : f_dec(r_minute_set, 6'd59);
                SET_SEC:  r_second_set <= w_up ? f_inc(r_second_set, 6'd59) : f_dec(r_second_set, 6'd59);
                default: ;
            endcase
        end
    end

    assign hour_set   = r_hour_set;
    assign minute_set = r_minute_set;
    assign second_set = r_second_set;

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: stimulus queues expected output snapshots,
// a monitor pops one whenever the DUT outputs change.
module tb_time_setter;

    logic       clk = 1'b0;
    logic       rst_n, key_mode, key_up, key_down;
    logic [5:0] hour_now, minute_now, second_now;
    logic       set_en, load;
    logic [5:0] hour_set, minute_set, second_set;
    logic [1:0] field_sel;

    always #5 clk = ~clk;

    time_setter #(
        .DEBOUNCE_CYCLES(20'd4),
        .REPEAT_CYCLES  (24'd16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_up    (key_up),
        .key_down  (key_down),
        .hour_now  (hour_now),
        .minute_now(minute_now),
        .second_now(second_now),
        .set_en    (set_en),
        .hour_set  (hour_set),
        .minute_set(minute_set),
        .second_set(second_set),
        .field_sel (field_sel),
        .load      (load)
    );

    logic [21:0] exp_q[$];
    logic [21:0] prev, expv;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          load_w = 0;
    logic [5:0]  mv;
    wire  [21:0] cur = {set_en, field_sel, hour_set, minute_set, second_set, load};

    // Snapshot layout: {set_en, field_sel, hour, minute, second, load}
    always @(negedge clk) begin
        if (mon_en) begin
            if (cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change got=%h required=no change", cur);
                end else begin
                    expv = exp_q.pop_front();
                    if (cur !== expv) begin
                        errors++;
                        $display("FAIL snapshot got=%h required=%h", cur, expv);
                    end
                end
            end
            if (load) begin
                load_w++;
            end else if (load_w != 0) begin
                checks++;
                if (load_w != 1) begin
                    errors++;
                    $display("FAIL load_width got=%0d required=1", load_w);
                end
                load_w = 0;
            end
            prev = cur;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic en, input logic [1:0] fs, input logic [5:0] h,
                        input logic [5:0] m, input logic [5:0] s, input logic ld);
        exp_q.push_back({en, fs, h, m, s, ld});
    endtask

    task automatic press(input logic m, input logic u, input logic d, input int hold = 12);
        key_mode = m;
        key_up   = u;
        key_down = d;
        wait_cyc(hold);
        key_mode = 1'b0;
        key_up   = 1'b0;
        key_down = 1'b0;
        wait_cyc(14);
    endtask

    initial begin
        rst_n = 1'b0; key_mode = 1'b0; key_up = 1'b0; key_down = 1'b0;
        hour_now = 6'd12; minute_now = 6'd34; second_now = 6'd56;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
        checks++;
        if (cur !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got=%h required=%h", cur, 22'd0);
        end
        prev   = cur;
        mon_en = 1'b1;

        // enter edit, step hour, walk fields, commit
        push(1, 1, 12, 34, 56, 0); press(1, 0, 0);
        push(1, 1, 13, 34, 56, 0); press(0, 1, 0);
        push(1, 1, 12, 34, 56, 0); press(0, 0, 1);
        push(1, 2, 12, 34, 56, 0); press(1, 0, 0);
        push(1, 3, 12, 34, 56, 0); press(1, 0, 0);
        push(1, 3, 12, 34, 57, 0); press(0, 1, 0);
        push(1, 0, 12, 34, 57, 1); push(0, 0, 12, 34, 57, 0); press(1, 0, 0);

        // idle: steps ignored, running time not tracked
        press(0, 1, 0);
        press(0, 0, 1);
        hour_now = 6'd23; minute_now = 6'd58; second_now = 6'd0;
        wait_cyc(5);

        // hour wrap both ways
        push(1, 1, 23, 58, 0, 0); press(1, 0, 0);
        push(1, 1, 0, 58, 0, 0);  press(0, 1, 0);
        push(1, 1, 23, 58, 0, 0); press(0, 0, 1);
        push(1, 1, 22, 58, 0, 0); press(0, 0, 1);

        // glitch shorter than debounce, and up+down together
        key_up = 1'b1; wait_cyc(3); key_up = 1'b0; wait_cyc(14);
        press(0, 1, 1);

        // minute: long hold of up
        push(1, 2, 22, 58, 0, 0); press(1, 0, 0);
        push(1, 2, 22, 59, 0, 0);
`ifdef TIME_SETTER_REPEAT_EN
        push(1, 2, 22, 0, 0, 0);
        push(1, 2, 22, 1, 0, 0);
        mv = 6'd1;
`else
        mv = 6'd59;
`endif
        press(0, 1, 0, 40);

        // second wrap down then commit
        push(1, 3, 22, mv, 0, 0);  press(1, 0, 0);
        push(1, 3, 22, mv, 59, 0); press(0, 0, 1);
        push(1, 0, 22, mv, 59, 1); push(0, 0, 22, mv, 59, 0); press(1, 0, 0);

        // mode coincident with up: transition only
        push(1, 1, 23, 58, 0, 0); press(1, 1, 0);
        push(1, 2, 23, 58, 0, 0); press(1, 1, 0);

        // reset in SET_MIN with up held through reset release
        push(0, 0, 0, 0, 0, 0);
        key_up = 1'b1;
        rst_n  = 1'b0;
        wait_cyc(3);
        rst_n  = 1'b1;
        wait_cyc(30);
        key_up = 1'b0;
        wait_cyc(14);

        // keys work again after release
        push(1, 1, 23, 58, 0, 0); press(1, 0, 0);
        push(1, 1, 0, 58, 0, 0);  press(0, 1, 0);
        push(1, 2, 0, 58, 0, 0);  press(1, 0, 0);
        push(1, 3, 0, 58, 0, 0);  press(1, 0, 0);
        push(1, 0, 0, 58, 0, 1);  push(0, 0, 0, 58, 0, 0); press(1, 0, 0);

        // out-of-range captured hour steps to 0
        hour_now = 6'd40;
        push(1, 1, 40, 58, 0, 0); press(1, 0, 0);
        push(1, 1, 0, 58, 0, 0);  press(0, 0, 1);

        wait_cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expect got=%0d left required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20'd1000000, meaning the number of clk cycles a synchronized key level must stay unchanged before it is accepted.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 24'd5000000, meaning the hold interval between auto-repeat steps; it applies only with TIME_SETTER_REPEAT_EN.
REQ-003 Port: clk, input, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port: rst_n, input, 1, synchronous active-low reset.
REQ-005 Port: key_mode, input, 1, raw mode key, active-high = pressed, asynchronous to clk.
REQ-006 Port: key_up, input, 1, raw increment key, active-high, asynchronous.
REQ-007 Port: key_down, input, 1, raw decrement key, active-high, asynchronous.
REQ-008 Port: hour_now / minute_now / second_now, input, 6 each, running time, captured when set mode is entered.
REQ-009 Port: set_en, output, 1, high while editing; it selects the edit values for display.
REQ-010 Port: hour_set / minute_set / second_set, output, 6 each, the values being edited.
REQ-011 Port: field_sel, output, 2, field being edited: 0 = none, 1 = hour, 2 = minute, 3 = second.
REQ-012 Port: load, output, 1, one-cycle pulse telling the timekeeper to copy the *_set values.

Function
REQ-013 Each key SHALL pass through a 2-FF synchronizer.
REQ-014 After synchronization, each key SHALL be debounced by a per-key counter: the debounced level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from it; any glitch restarts the count.
REQ-015 A press event SHALL be a one-cycle pulse on a 0->1 transition of a debounced level.
REQ-016 Latency from a stable raw edge to the press event SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles (±1).
REQ-017 The FSM SHALL have states IDLE, SET_HOUR, SET_MIN, SET_SEC and COMMIT.
REQ-018 In IDLE, a mode press SHALL capture *_now into *_set and move to SET_HOUR.
REQ-019 A mode press SHALL advance the FSM SET_HOUR -> SET_MIN -> SET_SEC -> COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle with load = 1, then return to IDLE.
REQ-021 set_en SHALL be 1 in SET_HOUR, SET_MIN, SET_SEC and COMMIT, and 0 in IDLE.
REQ-022 field_sel SHALL be 1, 2 or 3 in the matching SET state and 0 otherwise.
REQ-023 An up or down press in a SET state SHALL step the selected field by ±1 on the next cycle.
REQ-024 The hour field SHALL wrap 23->0 and 0->23; the minute and second fields SHALL wrap 59->0 and 0->59.
REQ-025 Stepping from an out-of-range captured value SHALL first set the field to 0.
REQ-026 Up and down press events in the same cycle SHALL produce no change.
REQ-027 A mode press coincident with an up or down press SHALL apply the mode transition only; the step is discarded.
REQ-028 Up and down presses in IDLE or COMMIT SHALL be ignored.
REQ-029 *_set SHALL hold its value in IDLE; the running time is captured only on entry to SET_HOUR.

Reset
REQ-030 When rst_n = 0 at a clk edge, the FSM SHALL go to IDLE and set_en = 0, load = 0, field_sel = 0, *_set = 0, with all debounce counters, debounced levels and repeat counters cleared.
REQ-031 A reset during SET_* or COMMIT SHALL abort the edit without a load pulse.
REQ-032 A key held through the release of reset SHALL NOT generate a press until it has been released and pressed again.

Configuration
REQ-033 With TIME_SETTER_REPEAT_EN defined, holding debounced up or down in a SET state SHALL generate an additional step after REPEAT_CYCLES and every REPEAT_CYCLES after that, until release; holding both keys SHALL generate no repeats.
REQ-034 With TIME_SETTER_REPEAT_EN undefined, exactly one step per press SHALL occur and no repeat counter SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16)
REQ-035 Setup: now = 12:34:56, press mode.
- Required: set_en = 1, field_sel = 1, hour_set = 12, minute_set = 34, second_set = 56.
REQ-036 Setup: SET_HOUR with hour_set = 23, press up; then press down twice.
- Required: hour_set = 0 after the up press, then 23, then 22.
REQ-037 Setup: SET_SEC with second_set = 0, press down; then press mode.
- Required: second_set = 59, then load = 1 for exactly 1 cycle, then IDLE with set_en = 0 and field_sel = 0.
REQ-038 Setup: key_up glitches high for 3 cycles; separately, up and down are pressed together.
- Required: no change in either case.
REQ-039 Setup: reset asserted in SET_MIN.
- Required: next cycle all outputs are 0, no load pulse occurs, and a key held through reset release gives no step.
REQ-040 Setup: TIME_SETTER_REPEAT_EN defined, SET_MIN with minute_set = 58, up held for 1 + 2×16 cycles after the press.
- Required: minute_set goes 59, 0, 1.
